// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the Pong renderer.
//   color_t  - packed RGB pixel, CHAN_W bits per channel
//   state_t  - serve state machine encoding (PLAY, SERVE)
//   COLOR_*  - fixed palette for background, ball, paddle and net
package pong_pkg;

    localparam int CHAN_W = 4;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } color_t;

    typedef enum logic {
        PLAY  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam color_t COLOR_BG     = color_t'(12'h142);
    localparam color_t COLOR_BALL   = color_t'(12'hFFF);
    localparam color_t COLOR_PADDLE = color_t'(12'h63F);
    localparam color_t COLOR_NET    = color_t'(12'h888);

endpackage

// File: rtl/pong_physics.sv
// pong_physics: per-frame game state for Pong.
//   Holds ball position/direction, paddle position and the serve state
//   machine. Every register advances only on cycles where frame = 1.
// Ports:
//   clk_pix, rst_pix   - pixel clock, synchronous active-high reset
//   frame              - one-cycle update strobe (vertical blanking)
//   btn_up, btn_dn     - synchronised paddle buttons (level)
//   bx, by             - ball top-left corner, active coordinates
//   py                 - paddle top row, active coordinates
//   ball_vis           - ball is drawn (PLAY state)
//   miss               - one-cycle pulse after the frame that lost the ball
module pong_physics
    import pong_pkg::*;
#(
    parameter int CORDW        = 10,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PAD_X        = 16,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 48,
    parameter int PAD_SPEED    = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             frame,
    input  logic             btn_up,
    input  logic             btn_dn,
    output logic [CORDW-1:0] bx,
    output logic [CORDW-1:0] by,
    output logic [CORDW-1:0] py,
    output logic             ball_vis,
    output logic             miss
);

    // One extra bit of signed headroom so +/- speed can never wrap.
    typedef logic signed [CORDW:0] sc_t;

    localparam sc_t B_SPD    = sc_t'(BALL_SPEED);
    localparam sc_t P_SPD    = sc_t'(PAD_SPEED);
    localparam sc_t B_SIZE   = sc_t'(BALL_SIZE);
    localparam sc_t P_H      = sc_t'(PAD_H);
    localparam sc_t BX_MAX   = sc_t'(H_RES - BALL_SIZE);
    localparam sc_t BY_MAX   = sc_t'(V_RES - BALL_SIZE);
    localparam sc_t PY_MAX   = sc_t'(V_RES - PAD_H);
    localparam sc_t PAD_EDGE = sc_t'(PAD_X + PAD_W);

    localparam logic [CORDW-1:0] BX_CTR = CORDW'((H_RES - BALL_SIZE) / 2);
    localparam logic [CORDW-1:0] BY_CTR = CORDW'((V_RES - BALL_SIZE) / 2);
    localparam logic [CORDW-1:0] PY_CTR = CORDW'((V_RES - PAD_H) / 2);

    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_t             state, state_n;
    logic               dx, dy, dx_n, dy_n;
    logic [CORDW-1:0]   bx_n, by_n, py_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               miss_n;
    logic               paddle_hit;

    sc_t bx_s, by_s, py_s;
    sc_t bx_inc, bx_dec, by_inc, by_dec, py_t;

    assign bx_s   = $signed({1'b0, bx});
    assign by_s   = $signed({1'b0, by});
    assign py_s   = $signed({1'b0, py});
    assign bx_inc = bx_s + B_SPD;
    assign bx_dec = bx_s - B_SPD;
    assign by_inc = by_s + B_SPD;
    assign by_dec = by_s - B_SPD;

    always_comb begin
        state_n    = state;
        bx_n       = bx;
        by_n       = by;
        py_n       = py;
        dx_n       = dx;
        dy_n       = dy;
        cnt_n      = cnt;
        miss_n     = 1'b0;
        paddle_hit = 1'b0;
        py_t       = py_s;

        if (frame) begin
            // Paddle moves in either state; opposing buttons cancel.
            if (btn_up && !btn_dn) begin
                py_t = py_s - P_SPD;
                py_n = py_t[CORDW] ? '0 : py_t[CORDW-1:0];
            end else if (btn_dn && !btn_up) begin
                py_t = py_s + P_SPD;
                py_n = (py_t > PY_MAX) ? PY_MAX[CORDW-1:0] : py_t[CORDW-1:0];
            end

            case (state)
                PLAY: begin
                    if (dy) begin
                        if (by_inc >= BY_MAX) begin
                            by_n = BY_MAX[CORDW-1:0];
                            dy_n = 1'b0;
                        end else begin
                            by_n = by_inc[CORDW-1:0];
                        end
                    end else begin
                        if (by_s <= B_SPD) begin
                            by_n = '0;
                            dy_n = 1'b1;
                        end else begin
                            by_n = by_dec[CORDW-1:0];
                        end
                    end

                    if (dx) begin
                        if (bx_inc >= BX_MAX) begin
                            bx_n = BX_MAX[CORDW-1:0];
                            dx_n = 1'b0;
                        end else begin
                            bx_n = bx_inc[CORDW-1:0];
                        end
                    end else begin
                        // Overlap uses the paddle position from before this frame's move.
                        paddle_hit = (bx_s >= PAD_EDGE) && (bx_dec <= PAD_EDGE)
                                  && (by_s + B_SIZE > py_s) && (by_s < py_s + P_H);
                        if (paddle_hit) begin
                            bx_n = PAD_EDGE[CORDW-1:0];
                            dx_n = 1'b1;
                        end else if (bx_s <= B_SPD) begin
                            // Lost ball: recentre, keep vertical direction, wait out the serve.
                            bx_n    = BX_CTR;
                            by_n    = BY_CTR;
                            dx_n    = 1'b1;
                            dy_n    = dy;
                            state_n = SERVE;
                            cnt_n   = '0;
                            miss_n  = 1'b1;
                        end else begin
                            bx_n = bx_dec[CORDW-1:0];
                        end
                    end
                end

                SERVE: begin
                    if (cnt == CNT_LAST) begin
                        state_n = PLAY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state <= PLAY;
            bx    <= BX_CTR;
            by    <= BY_CTR;
            py    <= PY_CTR;
            dx    <= 1'b1;
            dy    <= 1'b1;
            cnt   <= '0;
            miss  <= 1'b0;
        end else begin
            state <= state_n;
            bx    <= bx_n;
            by    <= by_n;
            py    <= py_n;
            dx    <= dx_n;
            dy    <= dy_n;
            cnt   <= cnt_n;
            miss  <= miss_n;
        end
    end

    assign ball_vis = (state == PLAY);

endmodule

// File: rtl/pong_render.sv
// pong_render: Pong pixel renderer for the VGA path.
//   Translates raw timing counters to active coordinates, tests the pixel
//   against ball, paddle and centre net, and registers the colour.
//   Pixel latency is one clock; upstream syncs need one matching delay.
// Ports:
//   clk_pix, rst_pix        - pixel clock, synchronous active-high reset
//   frame                   - one-cycle per-frame update strobe
//   de, sx, sy              - display enable and raw counters
//   btn_up, btn_dn          - synchronised paddle buttons
//   dispcolor_r/g/b         - registered colour to the DAC
//   miss                    - one-cycle pulse when the ball leaves the left edge
module pong_render
    import pong_pkg::*;
#(
    parameter int CORDW        = 10,
    parameter int CHANW        = 4,
    parameter int H_OFFSET     = 48,
    parameter int V_OFFSET     = 33,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PAD_X        = 16,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 48,
    parameter int PAD_SPEED    = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             frame,
    input  logic             de,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             btn_up,
    input  logic             btn_dn,
    output logic [CHANW-1:0] dispcolor_r,
    output logic [CHANW-1:0] dispcolor_g,
    output logic [CHANW-1:0] dispcolor_b,
    output logic             miss
);

    typedef logic signed [CORDW:0] sc_t;

    localparam sc_t H_OFF  = sc_t'(H_OFFSET);
    localparam sc_t V_OFF  = sc_t'(V_OFFSET);
    localparam sc_t B_SIZE = sc_t'(BALL_SIZE);
    localparam sc_t P_L    = sc_t'(PAD_X);
    localparam sc_t P_R    = sc_t'(PAD_X + PAD_W);
    localparam sc_t P_H    = sc_t'(PAD_H);
    localparam sc_t NET_L  = sc_t'(H_RES / 2 - 1);
    localparam sc_t NET_R  = sc_t'(H_RES / 2);

    logic [CORDW-1:0] bx, by, py;
    logic             ball_vis;

    pong_physics #(
        .CORDW        (CORDW),
        .H_RES        (H_RES),
        .V_RES        (V_RES),
        .BALL_SIZE    (BALL_SIZE),
        .BALL_SPEED   (BALL_SPEED),
        .PAD_X        (PAD_X),
        .PAD_W        (PAD_W),
        .PAD_H        (PAD_H),
        .PAD_SPEED    (PAD_SPEED),
        .SERVE_FRAMES (SERVE_FRAMES)
    ) u_physics (
        .clk_pix  (clk_pix),
        .rst_pix  (rst_pix),
        .frame    (frame),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .bx       (bx),
        .by       (by),
        .py       (py),
        .ball_vis (ball_vis),
        .miss     (miss)
    );

    sc_t    ax_p0, ay_p0, bx_s, by_s, py_s;
    logic   ball_hit_p0, pad_hit_p0, net_hit_p0;
    color_t pix_p0;

    // Stage p0: coordinate translation and object hit tests.
    assign ax_p0 = $signed({1'b0, sx}) - H_OFF;
    assign ay_p0 = $signed({1'b0, sy}) - V_OFF;
    assign bx_s  = $signed({1'b0, bx});
    assign by_s  = $signed({1'b0, by});
    assign py_s  = $signed({1'b0, py});

    assign ball_hit_p0 = ball_vis
                      && (ax_p0 >= bx_s) && (ax_p0 < bx_s + B_SIZE)
                      && (ay_p0 >= by_s) && (ay_p0 < by_s + B_SIZE);
    assign pad_hit_p0  = (ax_p0 >= P_L) && (ax_p0 < P_R)
                      && (ay_p0 >= py_s) && (ay_p0 < py_s + P_H);
    // Dashed net: 8 rows on, 8 rows off.
    assign net_hit_p0  = ((ax_p0 == NET_L) || (ax_p0 == NET_R)) && !ay_p0[3];

    always_comb begin
        pix_p0 = COLOR_BG;
        if (ball_hit_p0) begin
            pix_p0 = COLOR_BALL;
        end else if (pad_hit_p0) begin
            pix_p0 = COLOR_PADDLE;
        end else if (net_hit_p0) begin
            pix_p0 = COLOR_NET;
        end
    end

    // Stage p1: registered colour, blanked outside the active area.
    always_ff @(posedge clk_pix) begin
        if (rst_pix || !de) begin
            dispcolor_r <= '0;
            dispcolor_g <= '0;
            dispcolor_b <= '0;
        end else begin
            dispcolor_r <= CHANW'(pix_p0.r);
            dispcolor_g <= CHANW'(pix_p0.g);
            dispcolor_b <= CHANW'(pix_p0.b);
        end
    end

endmodule

// File: doc/pong_render.md
# pong_render

Parametrised Pong renderer for the VGA pixel path. Sits between the display timing generator (supplies `de`, `sx`, `sy`, `frame`) and the 4-bit-per-channel DAC outputs. Replaces the fixed-rectangle combinational renderer with moving objects, held in registers updated once per frame:
- a ball that bounces off walls and the paddle;
- a player-driven paddle;
- a dashed centre net;
- a serve state machine.

## Interface
- `CORDW`, 10, coordinate width of `sx`/`sy` and all position registers
- `CHANW`, 4, colour channel width
- `H_OFFSET`, 48, `sx` value of first active column
- `V_OFFSET`, 33, `sy` value of first active line
- `H_RES`, 640, active width
- `V_RES`, 480, active height
- `BALL_SIZE`, 8, ball side length (square)
- `BALL_SPEED`, 2, ball pixels per frame per axis
- `PAD_X`, 16, paddle left column (active coords)
- `PAD_W`, 8, paddle width
- `PAD_H`, 48, paddle height
- `PAD_SPEED`, 4, paddle pixels per frame
- `SERVE_FRAMES`, 60, frames held in SERVE after a miss
- `clk_pix` input 1: pixel clock; all logic on rising edge
- `rst_pix` input 1: reset, synchronous, active-high
- `frame` input 1: one-cycle pulse once per frame, during vertical blanking
- `de` input 1: display enable
- `sx` input CORDW: raw horizontal counter
- `sy` input CORDW: raw vertical counter
- `btn_up` input 1: paddle up, level, already synchronised
- `btn_dn` input 1: paddle down, level, already synchronised
- `dispcolor_r`, `dispcolor_g`, `dispcolor_b` output CHANW: registered pixel colour
- `miss` output 1: one-cycle pulse when the ball exits the left edge

## Operation
- Positions use active coordinates. Ball is (`bx`, `by`), top-left corner. Paddle top is `py`.
- Direction flags `dx`, `dy`: 1 = right/down.
- Reset values:
  - `bx` = (H_RES−BALL_SIZE)/2 = 316; `by` = (V_RES−BALL_SIZE)/2 = 236
  - `dx` = 1, `dy` = 1
  - `py` = (V_RES−PAD_H)/2 = 216
  - state PLAY, serve counter 0
- All position and state updates occur only on cycles where `frame` = 1.
- Next-position arithmetic is done in CORDW+1 signed bits so no wrap-around is possible.
- Paddle update:
  - `btn_up` only: `py` −= PAD_SPEED, clamped at 0.
  - `btn_dn` only: `py` += PAD_SPEED, clamped at V_RES−PAD_H.
  - Both or neither: no move.
  - Applies in both states.
- Ball update, PLAY state:
  - Vertical: if `dy` and `by`+BALL_SPEED ≥ V_RES−BALL_SIZE, set `by` = V_RES−BALL_SIZE and `dy` = 0. If !`dy` and `by` ≤ BALL_SPEED, set `by` = 0 and `dy` = 1. Otherwise `by` ± BALL_SPEED.
  - Right wall: same rule against H_RES−BALL_SIZE.
  - Paddle hit: !`dx`, `bx` ≥ PAD_X+PAD_W, `bx`−BALL_SPEED ≤ PAD_X+PAD_W, and vertical overlap (`by`+BALL_SIZE > `py` && `by` < `py`+PAD_H, using pre-update `py`). Result: `bx` = PAD_X+PAD_W, `dx` = 1.
  - Miss: !`dx` and `bx` ≤ BALL_SPEED without a paddle hit. Result: `miss` pulses; ball reloads centre; `dx` = 1; `dy` unchanged; state → SERVE; counter cleared.
  - Paddle-hit test has priority over the miss test.
- SERVE state:
  - Ball frozen at centre and not drawn.
  - Counter increments per `frame`.
  - On the `frame` where counter = SERVE_FRAMES−1: state → PLAY. Ball moves from the next `frame`.
- Pixel path:
  - `ax` = `sx`−H_OFFSET, `ay` = `sy`−V_OFFSET.
  - Priority: ball (PLAY only) → paddle → net → background.
  - Net: columns H_RES/2−1 and H_RES/2, where `ay`[3] = 0.
  - Colours come from the package constants.
  - `de` = 0 forces 0 on all channels.
- Reset (any time, including mid-frame or in SERVE): all registers and outputs take reset values. `rst_pix` beats a simultaneous `frame`.

## Timing
- Pixel latency: 1 cycle. `de`/`sx`/`sy` sampled at edge N appear on `dispcolor_*` after edge N. Upstream sync signals must be delayed 1 cycle to match.
- `dispcolor_*` and `miss` are 0 after a reset edge.
- `miss` is high for exactly the cycle after the `frame` edge that detected the miss.
- Positions change only at `frame` edges, so no tearing inside the active area.

## Structure
- Package `pong_pkg` holds:
  - `color_t` struct (r, g, b, each CHANW bits)
  - state enum `{PLAY, SERVE}`
  - colour constants: background 0x142, ball 0xFFF, paddle 0x63F, net 0x888
- Sub-module `pong_physics` holds per-frame position, direction, serve FSM and `miss`. It outputs `bx`, `by`, `py`, `ball_vis`.
- `pong_render` keeps the coordinate translation, hit tests and output register.

## Test plan
- Reset, then `de` = 1 at `sx` = 364, `sy` = 269 → ball colour 0xFFF one cycle later. `sx` = 40 → 0x000. Both checked with `miss` = 0.
- 10 `frame` pulses, no buttons → `bx` = 336, `by` = 256. Pixel at raw (384, 289) = ball.
- `btn_up` held 60 frames → `py` clamps at 0, never wraps. Both buttons held → `py` unchanged.
- Force `dy` down near bottom (`by` = 471) → after one `frame`, `by` = 472 and `dy` = 0. Next `frame`: `by` = 470.
- Ball moving left at `bx` = 25, `by` = `py`+10 → after `frame`, `bx` = 24 and `dx` = 1, no `miss`. Same with the paddle out of range → `miss` pulse within 13 frames, ball hidden for 60 frames, then reappears at (316, 236) moving right.
- Assert `rst_pix` together with `frame` while in SERVE → state PLAY, reset positions, outputs 0 the next cycle.
